// File: rtl/riscv_param.sv
// Shared constants and types for the write-back path.
// Register width, index width and the write-back FSM encoding.
package riscv_param;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int SRC_W = 2;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// Write-back bundle: requester handshakes plus the
// registered register-file write port.
interface riscv_wb_arbiter_if #(
  parameter int XLEN = riscv_param::XLEN,
  parameter int NREQ = 3
);
  import riscv_param::*;

  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ*REG_W-1:0] i_req_rd;
  logic [NREQ*XLEN-1:0]  i_req_data;
  logic [NREQ-1:0]       o_req_ready;
  logic                  i_flush;
  logic                  o_wr_en;
  logic [REG_W-1:0]      o_wr_rd;
  logic [XLEN-1:0]       o_wr_data;
  logic [SRC_W-1:0]      o_wr_src;

  modport master (
    output i_req_valid,
    output i_req_rd,
    output i_req_data,
    output i_flush,
    input  o_req_ready,
    input  o_wr_en,
    input  o_wr_rd,
    input  o_wr_data,
    input  o_wr_src
  );

  modport slave (
    input  i_req_valid,
    input  i_req_rd,
    input  i_req_data,
    input  i_flush,
    output o_req_ready,
    output o_wr_en,
    output o_wr_rd,
    output o_wr_data,
    output o_wr_src
  );

endinterface

// File: rtl/riscv_rr_picker.sv
// Round-robin one-hot picker: first valid at or above ptr,
// wrapping modulo NREQ; nothing granted when disabled.
module riscv_rr_picker
  import riscv_param::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [SRC_W-1:0] ptr,
  input  logic             enable,
  output logic [NREQ-1:0]  grant
);

  logic             found;
  logic [SRC_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = SRC_W'((int'(ptr) + k) % NREQ);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: round-robin grant among requesters,
// one registered register-file write per cycle.
module riscv_wb_arbiter #(
  parameter int XLEN = riscv_param::XLEN,
  parameter int NREQ = 3
) (
  input  logic               i_register_clk,
  input  logic               i_register_rstn,
  riscv_wb_arbiter_if.slave  bus
);
  import riscv_param::*;

  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] win;
  logic [SRC_W-1:0] ptr_nxt;
  logic [REG_W-1:0] sel_rd;
  logic [XLEN-1:0]  sel_data;
  wb_state_e        state;
  logic [REG_W-1:0] wr_rd;
  logic [XLEN-1:0]  wr_data;
  logic [SRC_W-1:0] wr_src;

  // Ready depends only on valid, flush and ptr.
  riscv_rr_picker #(
    .NREQ (NREQ)
  ) u_pick (
    .valid  (bus.i_req_valid),
    .ptr    (ptr),
    .enable (!bus.i_flush),
    .grant  (grant)
  );

  assign bus.o_req_ready = grant;
  assign xfer = |grant;

  always_comb begin
    win      = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win      = SRC_W'(i);
        sel_rd   = bus.i_req_rd[REG_W*i +: REG_W];
        sel_data = bus.i_req_data[XLEN*i +: XLEN];
      end
    end
    ptr_nxt = (win == SRC_W'(NREQ-1)) ? '0 : win + 1'b1;
  end

  // Writes to x0 are accepted but never reach the file.
  always_ff @(posedge i_register_clk or negedge i_register_rstn) begin
    if (!i_register_rstn) begin
      state   <= WB_IDLE;
      ptr     <= '0;
      wr_rd   <= '0;
      wr_data <= '0;
      wr_src  <= '0;
    end else begin
      state <= WB_IDLE;
      if (xfer) begin
        ptr <= ptr_nxt;
        if (sel_rd != '0) begin
          state   <= WB_WRITE;
          wr_rd   <= sel_rd;
          wr_data <= sel_data;
          wr_src  <= win;
        end
      end
    end
  end

  assign bus.o_wr_en   = (state == WB_WRITE);
  assign bus.o_wr_rd   = wr_rd;
  assign bus.o_wr_data = wr_data;
  assign bus.o_wr_src  = wr_src;

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREQ, default 3, number of write-back requesters (ALU, load, CSR); legal range 2..4.
REQ-003 SHALL have port i_register_clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port i_register_rstn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port i_req_valid  input  NREQ  per-requester write request.
REQ-006 SHALL have port i_req_rd  input  NREQ*5  destination register index; requester i occupies bits [5i+4:5i].
REQ-007 SHALL have port i_req_data  input  NREQ*XLEN  write data; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
REQ-008 SHALL have port o_req_ready  output  NREQ  one-hot grant; combinational.
REQ-009 SHALL have port i_flush  input  1  pipeline flush; blocks all grants this cycle.
REQ-010 SHALL have port o_wr_en  output  1  register-file write strobe.
REQ-011 SHALL have port o_wr_rd  output  5  register-file write index.
REQ-012 SHALL have port o_wr_data  output  XLEN  register-file write data.
REQ-013 SHALL have port o_wr_src  output  2  index of the requester that produced the current write.

Function
REQ-014 SHALL grant at most one requester per cycle; o_req_ready SHALL be zero or one-hot.
REQ-015 SHALL choose the winner round-robin: search from pointer ptr upward modulo NREQ; the first set i_req_valid bit wins.
REQ-016 SHALL treat a transfer as i_req_valid[i] & o_req_ready[i]; o_req_ready SHALL never be set for a non-valid requester.
REQ-017 SHALL set ptr to (winner+1) mod NREQ after a transfer; ptr SHALL hold when no transfer occurs.
REQ-018 SHALL register the transfer: o_wr_rd/o_wr_data/o_wr_src SHALL present the winner's fields one cycle after the transfer (latency 1).
REQ-019 SHALL assert o_wr_en for exactly one cycle per transfer, except when the transferred rd is 0: accept (ready high) but keep o_wr_en 0.
REQ-020 SHALL hold o_wr_rd/o_wr_data/o_wr_src at their last values when o_wr_en is 0.
REQ-021 SHALL, when i_flush=1, force o_req_ready=0, leave ptr unchanged, and drive o_wr_en=0 the next cycle; a write already presented this cycle is not cancelled.
REQ-022 SHALL sustain one write per cycle back-to-back with no bubble.
REQ-023 SHALL implement a two-state FSM: IDLE (o_wr_en=0) and WRITE (o_wr_en=1); IDLE->WRITE on a transfer with rd!=0; WRITE->WRITE on the same; otherwise ->IDLE.
REQ-024 SHALL hold o_req_ready combinational from i_req_valid, i_flush and ptr only; no combinational path from i_req_rd or i_req_data to o_req_ready.

Reset
REQ-025 SHALL, while i_register_rstn=0, hold o_wr_en=0, o_wr_rd=0, o_wr_data=0, o_wr_src=0, ptr=0, FSM=IDLE, regardless of the clock.
REQ-026 SHALL drop any in-flight write when reset asserts mid-operation; after release the first grant SHALL use ptr=0.

Structure
REQ-027 SHALL take XLEN, the register index width (5) and the FSM state encoding from the shared package riscv_param.
REQ-028 SHALL place the round-robin search in one combinational sub-module, riscv_rr_picker (inputs valid, ptr, enable; output one-hot grant).

Verification
REQ-029 Reset: assert rstn=0 mid-write with o_wr_en=1 -> o_wr_en, o_wr_rd, o_wr_data, o_wr_src all 0 immediately; after release, valids 3'b111 -> grant 3'b001.
REQ-030 Round-robin: valids 3'b111 held 6 cycles, rd 1/2/3 -> grants 001,010,100,001,010,100; o_wr_src 0,1,2,0,1,2 one cycle later, with o_wr_en continuously 1.
REQ-031 x0 drop: requester 1 alone, rd=0, data 0xDEADBEEF -> ready[1]=1, o_wr_en stays 0, ptr advances to 2.
REQ-032 Flush: valids 3'b101, i_flush=1 for 1 cycle -> ready 000 that cycle, o_wr_en=0 next; following cycle grant 001 (ptr unchanged).
REQ-033 Single requester: only valid[2] for 3 cycles, rd=5, data 1,2,3 -> 3 consecutive writes to x5 with data 1,2,3 and o_wr_src=2.
REQ-034 Idle hold: after a write of rd=7, data 0x12345678, all valids 0 -> o_wr_en=0, o_wr_rd=7, o_wr_data=0x12345678 held.
